mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers. Sits in the EX stage beside the single-cycle ALU.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and serves MFHI/MFLO reads and MTHI/MTLO writes.
//  Asserts busy so hazard logic stalls IF/ID/EX while an operation is in flight.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; even, >= 4
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  start        in   1        launch op; sampled only when busy==0
//  op           in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a            in   WIDTH    rs operand (multiplicand / dividend)
//  b            in   WIDTH    rt operand (multiplier / divisor)
//  abort        in   1        pipeline flush; cancels in-flight op
//  hi_we        in   1        MTHI write enable
//  lo_we        in   1        MTLO write enable
//  wdata        in   WIDTH    MTHI/MTLO data
//  busy         out  1        op in flight
//  done         out  1        one-cycle pulse: HI/LO just updated by an op
//  div_by_zero  out  1        sticky for last op: divisor was zero
//  hi           out  WIDTH    HI register (MULT upper half / DIV remainder)
//  lo           out  WIDTH    LO register (MULT lower half / DIV quotient)
// BEHAVIOUR
//  Reset: state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter=0. Reset mid-op drops the op immediately.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 at edge T -> latch |a|,|b| (magnitudes for signed ops, raw for unsigned), sign flags, op; count=WIDTH;
//         busy=1 from edge T; div_by_zero <= (op[1] && b==0) at edge T.
//   CALC: one bit per cycle. Multiply: shift-add into 2*WIDTH accumulator. Divide: restoring shift-subtract.
//         count decrements each edge; leaves for FIX when count reaches 1 (WIDTH edges in CALC: T+1..T+WIDTH).
//   FIX: at edge T+WIDTH+1 apply sign correction, write hi/lo, done=1 for one cycle, busy=0, back to IDLE.
//  Latency: start edge T -> hi/lo valid and done=1 after edge T+WIDTH+1. busy high for exactly WIDTH+1 cycles.
//  Back-to-back: start is accepted in the cycle done is high (busy already 0).
//  Sign rules: MULT product negated if a,b signs differ (2*WIDTH-bit negate). DIV quotient negated if signs differ;
//   remainder takes the dividend's sign. Unsigned ops ignore operand MSBs as sign.
//  Magnitudes are WIDTH-bit unsigned: |MIN_INT| = 2^(WIDTH-1), so MIN_INT / -1 -> lo=MIN_INT, hi=0 (no trap).
//  Divide by zero: full latency still taken; result hi=a (unmodified dividend), lo=all ones; div_by_zero=1.
//  start while busy: ignored (no queueing, no effect on in-flight op).
//  abort while busy: next edge -> IDLE, busy=0, done=0; hi/lo keep pre-op values; div_by_zero cleared.
//   abort and FIX on the same edge: abort wins, no write. abort while IDLE: no effect.
//  hi_we/lo_we: write wdata at next edge only when busy==0 and start==0; dropped otherwise
//   (start wins over MT writes; hazard logic guarantees stall). hi_we and lo_we both set: both written.
//  hi/lo are registers, readable every cycle; unchanged during CALC (intermediate state kept internal).
//  done never asserts for an aborted op or for MT writes.
// TESTING (WIDTH=32)
//  MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 edges hi=FFFFFFFE lo=00000001, done 1 cycle, busy 33 cycles.
//  MULT a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF lo=FFFFFFEB; DIVU a=100 b=7 -> lo=14 hi=2.
//  DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  DIV a=5 b=0 -> hi=5 lo=FFFFFFFF div_by_zero=1; next DIVU 9/3 -> div_by_zero=0 lo=3 hi=0.
//  Start MULT, pulse abort at 10th busy cycle, second start during busy -> busy falls next edge, hi/lo unchanged, no done.
//  MTHI wdata=1234 while idle -> hi=1234; MTLO during busy dropped; rst asserted mid-DIV -> all outputs 0 at once.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide unit.
//  master : pipeline side, drives start/op/a/b/abort and the MTHI/MTLO write port,
//           observes busy/done/div_by_zero and the HI/LO registers.
//  slave  : the mips_muldiv_unit itself.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One result bit per cycle; busy stalls the front of the pipe while an op runs.
//  clk, rst         : rising-edge clock, asynchronous active-high reset
//  bus.start/op/a/b : launch (op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV), taken only when idle
//  bus.abort        : flush, cancels an in-flight op without touching HI/LO
//  bus.hi_we/lo_we/wdata : MTHI/MTLO, honoured only when idle and not starting
//  bus.busy/done/div_by_zero : status; done pulses one cycle when an op writes HI/LO
//  bus.hi/lo        : HI (product upper / remainder), LO (product lower / quotient)
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mips_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // r:q is the working pair: product upper:lower for multiply,
    // partial remainder:dividend/quotient for divide.
    logic [WIDTH-1:0] r, q, m;
    logic [WIDTH-1:0] a_raw;     // kept for the divide-by-zero result
    logic             is_div;
    logic             neg_q;     // product / quotient must be negated
    logic             neg_r;     // remainder must be negated (dividend negative)

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_rs;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] r_nxt, q_nxt;

    // Signed ops work on magnitudes; MIN_INT maps to 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit value.
    always_comb begin
        abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, then
        // shift the whole 2*WIDTH pair right, carry included.
        mul_sum  = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
        // Restoring divide: shift the next dividend bit in and subtract when it fits.
        div_rs   = {r, q[WIDTH-1]};
        div_ge   = div_rs >= {1'b0, m};
        div_diff = div_rs[WIDTH-1:0] - m;   // only used when it fits, so the top bit is 0
        if (is_div) begin
            r_nxt = div_ge ? div_diff : div_rs[WIDTH-1:0];
            q_nxt = {q[WIDTH-2:0], div_ge};
        end else begin
            r_nxt = mul_sum[WIDTH:1];
            q_nxt = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            r               <= '0;
            q               <= '0;
            m               <= '0;
            a_raw           <= '0;
            is_div          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r               <= '0;
                        q               <= abs_a;
                        m               <= abs_b;
                        a_raw           <= bus.a;
                        is_div          <= bus.op[1];
                        neg_q           <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r           <= bus.op[0] & bus.a[WIDTH-1];
                        count           <= CW'(WIDTH);
                        bus.busy        <= 1'b1;
                        bus.div_by_zero <= bus.op[1] && (bus.b == '0);
                        state           <= CALC;
                    end else begin
                        // MT writes lose to start; hazard logic never issues both.
                        if (bus.hi_we) bus.hi <= bus.wdata;
                        if (bus.lo_we) bus.lo <= bus.wdata;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        bus.busy        <= 1'b0;
                        bus.div_by_zero <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        r     <= r_nxt;
                        q     <= q_nxt;
                        count <= count - CW'(1);
                        if (count == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    // abort on this edge still wins: HI/LO keep their pre-op values
                    if (bus.abort) begin
                        bus.div_by_zero <= 1'b0;
                    end else begin
                        if (bus.div_by_zero) begin
                            bus.hi <= a_raw;
                            bus.lo <= '1;
                        end else if (is_div) begin
                            bus.hi <= neg_r ? -r : r;
                            bus.lo <= neg_q ? -q : q;
                        end else begin
                            {bus.hi, bus.lo} <= neg_q ? -{r, q} : {r, q};
                        end
                        bus.done <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit at WIDTH=32. Inputs change on the
// falling edge (or 1ns after the rising edge); outputs are sampled on the
// falling edge.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb_, qq, rr;
        e.dbz = 1'b0;
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb_ = longint'($signed(b));
                p = 64'(sa * sb_);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    e.hi  = a;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    e.hi = a % b;
                    e.lo = a / b;
                end else begin
                    sa  = longint'($signed(a));
                    sb_ = longint'($signed(b));
                    qq  = sa / sb_;
                    rr  = sa % sb_;
                    p   = 64'(qq);
                    e.lo = p[31:0];
                    p   = 64'(rr);
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Called just after a falling edge; holds start across one rising edge.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, output logic [W-1:0] ph, output logic [W-1:0] pl);
        ph        = bus.hi;
        pl        = bus.lo;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sb.push_back(model(op, a, b));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; reports busy cycles seen and whether HI/LO moved while busy.
    task automatic collect(input logic [W-1:0] ph, input logic [W-1:0] pl,
                           output int cyc, output bit seen, output bit chg);
        cyc = 0; seen = 0; chg = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
            else if (bus.busy === 1'b1) begin
                cyc++;
                if (bus.hi !== ph || bus.lo !== pl) chg = 1;
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            bad++;
            $display("FAIL reset_in: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            bad++;
            $display("FAIL reset_out: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
    endtask

    task automatic test_arith();
        logic [1:0]   ops [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10};
        logic [W-1:0] as  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, -32'sd7, 32'h80000000,
                                   32'd5, 32'd9, 32'h80000000, 32'd7, 32'hFFFFFFFF};
        logic [W-1:0] bs  [10] = '{32'hFFFFFFFF, 32'd7, 32'd7, 32'd2, 32'hFFFFFFFF,
                                   32'd0, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'd1};
        logic [W-1:0] ph, pl;
        int  cyc;
        bit  seen, chg;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            launch(ops[i], as[i], bs[i], 1, ph, pl);
            total++;
            if (bus.div_by_zero !== (ops[i][1] && bs[i] == 0)) begin
                bad++;
                $display("FAIL dbz_at_start[%0d]: got %b want %b", i, bus.div_by_zero, ops[i][1] && bs[i] == 0);
            end
            collect(ph, pl, cyc, seen, chg);
            e = sb.pop_front();
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL arith_timeout[%0d]: done never seen", i);
                continue;
            end
            total++;
            if (cyc !== W + 1) begin bad++; $display("FAIL busy_len[%0d]: got %0d want %0d", i, cyc, W + 1); end
            total++;
            if (chg) begin bad++; $display("FAIL hilo_during_calc[%0d]: got changed want stable", i); end
            total++;
            if (bus.hi !== e.hi || bus.lo !== e.lo) begin
                bad++;
                $display("FAIL result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, ops[i], as[i], bs[i], bus.hi, bus.lo, e.hi, e.lo);
            end
            total++;
            if (bus.div_by_zero !== e.dbz || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL status_at_done[%0d]: got dbz=%b busy=%b want dbz=%b busy=0",
                         i, bus.div_by_zero, bus.busy, e.dbz);
            end
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse[%0d]: got done=%b want 0", i, bus.done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ph, pl;
        int  cyc;
        bit  seen, chg;
        exp_t e;
        launch(2'b01, 32'hFFFFFFF0, 32'd3, 1, ph, pl);
        collect(ph, pl, cyc, seen, chg);
        e = sb.pop_front();
        total++;
        if (!seen || bus.hi !== e.hi || bus.lo !== e.lo) begin
            bad++;
            $display("FAIL b2b_first: seen=%b got hi=%h lo=%h want hi=%h lo=%h", seen, bus.hi, bus.lo, e.hi, e.lo);
        end
        // start in the done cycle must be taken
        launch(2'b11, 32'd1000, 32'hFFFFFFF9, 1, ph, pl);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy); end
        collect(ph, pl, cyc, seen, chg);
        e = sb.pop_front();
        total++;
        if (!seen || cyc !== W + 1 || bus.hi !== e.hi || bus.lo !== e.lo) begin
            bad++;
            $display("FAIL b2b_second: seen=%b cyc=%0d got hi=%h lo=%h want hi=%h lo=%h cyc=%0d",
                     seen, cyc, bus.hi, bus.lo, e.hi, e.lo, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [1:0]   ops [3] = '{2'b01, 2'b11, 2'b00};
        logic [W-1:0] as  [3] = '{32'd3, 32'd5, 32'hFFFF};
        logic [W-1:0] bs  [3] = '{32'd5, 32'd0, 32'hFFFF};
        int           at  [3] = '{10, 5, 33};
        logic [W-1:0] ph, pl;
        bit stray;
        for (int i = 0; i < 3; i++) begin
            launch(ops[i], as[i], bs[i], 0, ph, pl);
            for (int k = 0; k < at[i]; k++) @(negedge clk);
            bus.abort = 1'b1;
            bus.start = 1'b1;   // ignored while busy
            bus.op    = 2'b00;
            bus.a     = 32'd2;
            bus.b     = 32'd2;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            @(negedge clk);
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL abort_status[%0d]: got busy=%b done=%b dbz=%b want 0 0 0",
                         i, bus.busy, bus.done, bus.div_by_zero);
            end
            total++;
            if (bus.hi !== ph || bus.lo !== pl) begin
                bad++;
                $display("FAIL abort_hilo[%0d]: got hi=%h lo=%h want hi=%h lo=%h", i, bus.hi, bus.lo, ph, pl);
            end
            stray = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1;
            end
            total++;
            if (stray) begin bad++; $display("FAIL abort_quiet[%0d]: got busy/done activity want none", i); end
        end
    endtask

    task automatic test_mt();
        logic [W-1:0] ph, pl;
        int  cyc;
        bit  seen, chg;
        exp_t e;
        pl = bus.lo;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1 bus.hi_we = 1'b0;
        @(negedge clk);
        total++;
        if (bus.hi !== 32'h1234 || bus.lo !== pl) begin
            bad++;
            $display("FAIL mthi: got hi=%h lo=%h want hi=00001234 lo=%h", bus.hi, bus.lo, pl);
        end
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
        @(posedge clk); #1 begin bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
        @(negedge clk);
        total++;
        if (bus.hi !== 32'hABCD || bus.lo !== 32'hABCD) begin
            bad++;
            $display("FAIL mt_both: got hi=%h lo=%h want 0000abcd 0000abcd", bus.hi, bus.lo);
        end
        // start together with MTLO: start wins, write dropped
        bus.lo_we = 1'b1; bus.wdata = 32'hDEAD;
        launch(2'b10, 32'd77, 32'd5, 1, ph, pl);
        bus.lo_we = 1'b0;
        total++;
        if (bus.lo !== 32'hABCD) begin bad++; $display("FAIL mt_vs_start: got lo=%h want 0000abcd", bus.lo); end
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
        @(posedge clk); #1 bus.lo_we = 1'b0;
        collect(ph, pl, cyc, seen, chg);
        e = sb.pop_front();
        total++;
        if (!seen || chg || bus.hi !== e.hi || bus.lo !== e.lo) begin
            bad++;
            $display("FAIL mt_during_busy: seen=%b chg=%b got hi=%h lo=%h want hi=%h lo=%h",
                     seen, chg, bus.hi, bus.lo, e.hi, e.lo);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] ph, pl;
        launch(2'b11, 32'd1000, 32'd0, 0, ph, pl);
        for (int k = 0; k < 5; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_dropped: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.abort = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_arith();
        test_back_to_back();
        test_abort();
        test_mt();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
